// File: rtl/regfile_pkg.sv
// Shared constants and enums for the register-file write-port arbiter.
// Ports: none (package only).
// Imported by rr_arbiter2 and regfile_write_arbiter.
package regfile_pkg;

  localparam int RF_DATA_WIDTH = 18;
  localparam int RF_ADDR_WIDTH = 4;
  localparam int RF_NUM_REGS   = 16;

  // Requester ids double as bit positions in the request/grant vectors.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_t;

  typedef enum logic {
    RUN  = 1'b0,
    INIT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered priority.
// Ports: clk/rst, req[1:0] (bit 0 = ALU, bit 1 = MEM), en (gates all grants), gnt[1:0].
// Priority moves to the other requester after every grant; it holds while en is low.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  req_id_t prio_q, prio_d;

  // Grant depends only on requests, enable and the priority flop, so a
  // requester's ready never loops back through its own valid.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0] && req[1]) begin
        gnt = (prio_q == REQ_ALU) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (gnt[0]) begin
      prio_d = REQ_MEM;
    end else if (gnt[1]) begin
      prio_d = REQ_ALU;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= REQ_ALU;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU and load writeback, with a zeroing init sequencer.
// Ports: CPU_CLOCK/CLEAR; ALU_* and MEM_* valid/ready requesters; INIT_START/INIT_BUSY;
//        REG_WRITE_ENABLE/WRITE_REG/WRITE_DATA to the register file; PENDING one-hot of the staged write.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int NUM_REGS   = RF_NUM_REGS
) (
  input  logic                  CPU_CLOCK,
  input  logic                  CLEAR,
  input  logic                  ALU_VALID,
  output logic                  ALU_READY,
  input  logic [ADDR_WIDTH-1:0] ALU_REG,
  input  logic [DATA_WIDTH-1:0] ALU_DATA,
  input  logic                  MEM_VALID,
  output logic                  MEM_READY,
  input  logic [ADDR_WIDTH-1:0] MEM_REG,
  input  logic [DATA_WIDTH-1:0] MEM_DATA,
  input  logic                  INIT_START,
  output logic                  INIT_BUSY,
  output logic                  REG_WRITE_ENABLE,
  output logic [ADDR_WIDTH-1:0] WRITE_REG,
  output logic [DATA_WIDTH-1:0] WRITE_DATA,
  output logic [NUM_REGS-1:0]   PENDING
);

  // Counter value of the last register; NUM_REGS equals 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH-1:0] LAST_REG = {ADDR_WIDTH{1'b1}};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] wreg_q, wreg_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;
  logic                  arb_en;
  logic [1:0]            gnt;

  // An INIT_START cycle blocks new grants so the first zero-write can take
  // the output stage on the very next edge.
  assign arb_en = (state_q == RUN) && !INIT_START;

  rr_arbiter2 u_arb (
    .clk (CPU_CLOCK),
    .rst (CLEAR),
    .req ({MEM_VALID, ALU_VALID}),
    .en  (arb_en),
    .gnt (gnt)
  );

  assign ALU_READY        = gnt[0];
  assign MEM_READY        = gnt[1];
  assign INIT_BUSY        = (state_q == INIT);
  assign REG_WRITE_ENABLE = we_q;
  assign WRITE_REG        = wreg_q;
  assign WRITE_DATA       = wdata_q;
  assign PENDING          = pending_q;

  // cnt_q tracks the register whose zero-write is currently in the output
  // stage, so the FSM leaves INIT on the edge that commits register LAST_REG.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    wreg_d  = '0;
    wdata_d = '0;
    case (state_q)
      RUN: begin
        if (INIT_START) begin
          state_d = INIT;
          cnt_d   = '0;
          we_d    = 1'b1;
        end else if (gnt[0]) begin
          we_d    = 1'b1;
          wreg_d  = ALU_REG;
          wdata_d = ALU_DATA;
        end else if (gnt[1]) begin
          we_d    = 1'b1;
          wreg_d  = MEM_REG;
          wdata_d = MEM_DATA;
        end
      end
      INIT: begin
        if (cnt_q == LAST_REG) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          we_d   = 1'b1;
          wreg_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pending_d = '0;
    if (we_d) begin
      pending_d[wreg_d] = 1'b1;
    end
  end

  always_ff @(posedge CPU_CLOCK or posedge CLEAR) begin
    if (CLEAR) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      wreg_q    <= '0;
      wdata_q   <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      wreg_q    <= wreg_d;
      wdata_q   <= wdata_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  typedef struct packed {
    logic        we;
    logic [3:0]  r;
    logic [17:0] d;
  } wr_t;

  logic        CPU_CLOCK = 1'b0;
  logic        CLEAR = 1'b0;
  logic        ALU_VALID = 1'b0, MEM_VALID = 1'b0, INIT_START = 1'b0;
  logic [3:0]  ALU_REG = '0, MEM_REG = '0;
  logic [17:0] ALU_DATA = '0, MEM_DATA = '0;
  logic        ALU_READY, MEM_READY, INIT_BUSY, REG_WRITE_ENABLE;
  logic [3:0]  WRITE_REG;
  logic [17:0] WRITE_DATA;
  logic [15:0] PENDING;
  logic [38:0] out_vec;

  int n_checks = 0;
  int n_pass   = 0;

  regfile_write_arbiter dut (
    .CPU_CLOCK        (CPU_CLOCK),
    .CLEAR            (CLEAR),
    .ALU_VALID        (ALU_VALID),
    .ALU_READY        (ALU_READY),
    .ALU_REG          (ALU_REG),
    .ALU_DATA         (ALU_DATA),
    .MEM_VALID        (MEM_VALID),
    .MEM_READY        (MEM_READY),
    .MEM_REG          (MEM_REG),
    .MEM_DATA         (MEM_DATA),
    .INIT_START       (INIT_START),
    .INIT_BUSY        (INIT_BUSY),
    .REG_WRITE_ENABLE (REG_WRITE_ENABLE),
    .WRITE_REG        (WRITE_REG),
    .WRITE_DATA       (WRITE_DATA),
    .PENDING          (PENDING)
  );

  always #5 CPU_CLOCK = ~CPU_CLOCK;

  assign out_vec = {REG_WRITE_ENABLE, WRITE_REG, WRITE_DATA, PENDING};

  // Expected {enable, reg, data, pending} for a write in the output stage.
  function automatic logic [38:0] exp_out(input wr_t w);
    logic [15:0] p;
    p = w.we ? (16'd1 << w.r) : 16'd0;
    return {w.we, w.r, w.d, p};
  endfunction

  task automatic tick();
    @(posedge CPU_CLOCK);
    #1;
  endtask

  task automatic do_reset();
    CLEAR = 1'b1;
    ALU_VALID = 1'b0; MEM_VALID = 1'b0; INIT_START = 1'b0;
    repeat (2) @(posedge CPU_CLOCK);
    #1 CLEAR = 1'b0;
  endtask

  task automatic test_reset();
    CLEAR = 1'b1;
    #1;
    n_checks++;
    if (out_vec !== 39'd0) $display("FAIL reset_outputs got=%h want=0", out_vec);
    else n_pass++;
    n_checks++;
    if ({INIT_BUSY, ALU_READY, MEM_READY} !== 3'b000)
      $display("FAIL reset_busy_ready got=%b want=000", {INIT_BUSY, ALU_READY, MEM_READY});
    else n_pass++;
    do_reset();
    ALU_VALID = 1'b1; MEM_VALID = 1'b1;
    #1;
    n_checks++;
    if ({ALU_READY, MEM_READY} !== 2'b10)
      $display("FAIL reset_priority got=%b want=10", {ALU_READY, MEM_READY});
    else n_pass++;
    ALU_VALID = 1'b0; MEM_VALID = 1'b0;
  endtask

  task automatic test_single_alu();
    do_reset();
    ALU_VALID = 1'b1; ALU_REG = 4'd3; ALU_DATA = 18'h2AAAA;
    @(negedge CPU_CLOCK);
    n_checks++;
    if ({ALU_READY, MEM_READY} !== 2'b10)
      $display("FAIL single_ready got=%b want=10", {ALU_READY, MEM_READY});
    else n_pass++;
    tick();
    ALU_VALID = 1'b0;
    @(negedge CPU_CLOCK);
    n_checks++;
    if (out_vec !== exp_out({1'b1, 4'd3, 18'h2AAAA}))
      $display("FAIL single_write got=%h want=%h", out_vec, exp_out({1'b1, 4'd3, 18'h2AAAA}));
    else n_pass++;
    tick();
    @(negedge CPU_CLOCK);
    n_checks++;
    if (out_vec !== 39'd0) $display("FAIL single_idle got=%h want=0", out_vec);
    else n_pass++;
  endtask

  task automatic test_alternate();
    logic [3:0] prev_r;
    logic [17:0] prev_d;
    do_reset();
    prev_r = '0; prev_d = '0;
    for (int i = 0; i < 4; i++) begin
      ALU_VALID = 1'b1; ALU_REG = 4'd1; ALU_DATA = 18'(100 + i);
      MEM_VALID = 1'b1; MEM_REG = 4'd2; MEM_DATA = 18'(200 + i);
      @(negedge CPU_CLOCK);
      n_checks++;
      if ({ALU_READY, MEM_READY} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
        $display("FAIL alt_grant[%0d] got=%b want=%b", i, {ALU_READY, MEM_READY},
                 (i % 2 == 0) ? 2'b10 : 2'b01);
      else n_pass++;
      if (i > 0) begin
        n_checks++;
        if (out_vec !== exp_out({1'b1, prev_r, prev_d}))
          $display("FAIL alt_write[%0d] got=%h want=%h", i, out_vec, exp_out({1'b1, prev_r, prev_d}));
        else n_pass++;
      end
      prev_r = (i % 2 == 0) ? 4'd1 : 4'd2;
      prev_d = (i % 2 == 0) ? 18'(100 + i) : 18'(200 + i);
      tick();
    end
    ALU_VALID = 1'b0; MEM_VALID = 1'b0;
    @(negedge CPU_CLOCK);
    n_checks++;
    if (out_vec !== exp_out({1'b1, 4'd2, 18'd203}))
      $display("FAIL alt_last got=%h want=%h", out_vec, exp_out({1'b1, 4'd2, 18'd203}));
    else n_pass++;
    tick();
  endtask

  task automatic test_mem_then_contest();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      MEM_VALID = 1'b1; MEM_REG = 4'(5 + i); MEM_DATA = 18'(i);
      ALU_VALID = (i == 3); ALU_REG = 4'd8; ALU_DATA = 18'd77;
      @(negedge CPU_CLOCK);
      n_checks++;
      if ({ALU_READY, MEM_READY} !== ((i == 3) ? 2'b10 : 2'b01))
        $display("FAIL memrun_grant[%0d] got=%b want=%b", i, {ALU_READY, MEM_READY},
                 (i == 3) ? 2'b10 : 2'b01);
      else n_pass++;
      tick();
    end
    ALU_VALID = 1'b0; MEM_VALID = 1'b0;
    tick();
  endtask

  task automatic test_init();
    do_reset();
    INIT_START = 1'b1;
    ALU_VALID = 1'b1; ALU_REG = 4'd7; ALU_DATA = 18'd5;
    @(negedge CPU_CLOCK);
    n_checks++;
    if ({ALU_READY, MEM_READY, INIT_BUSY} !== 3'b000)
      $display("FAIL init_start_cycle got=%b want=000", {ALU_READY, MEM_READY, INIT_BUSY});
    else n_pass++;
    tick();
    INIT_START = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge CPU_CLOCK);
      n_checks++;
      if ({out_vec, INIT_BUSY, ALU_READY} !== {exp_out({1'b1, 4'(k), 18'd0}), 2'b10})
        $display("FAIL init_zero[%0d] got=%h busy=%b rdy=%b want=%h busy=1 rdy=0",
                 k, out_vec, INIT_BUSY, ALU_READY, exp_out({1'b1, 4'(k), 18'd0}));
      else n_pass++;
      tick();
    end
    @(negedge CPU_CLOCK);
    n_checks++;
    if ({out_vec, INIT_BUSY, ALU_READY} !== {39'd0, 2'b01})
      $display("FAIL init_done got=%h busy=%b rdy=%b want=0 busy=0 rdy=1", out_vec, INIT_BUSY, ALU_READY);
    else n_pass++;
    tick();
    ALU_VALID = 1'b0;
    @(negedge CPU_CLOCK);
    n_checks++;
    if (out_vec !== exp_out({1'b1, 4'd7, 18'd5}))
      $display("FAIL init_after_alu got=%h want=%h", out_vec, exp_out({1'b1, 4'd7, 18'd5}));
    else n_pass++;
    tick();
  endtask

  task automatic test_grant_then_init();
    do_reset();
    ALU_VALID = 1'b1; ALU_REG = 4'd9; ALU_DATA = 18'h1234;
    tick();
    ALU_VALID = 1'b0; INIT_START = 1'b1;
    @(negedge CPU_CLOCK);
    n_checks++;
    if (out_vec !== exp_out({1'b1, 4'd9, 18'h1234}))
      $display("FAIL gti_first got=%h want=%h", out_vec, exp_out({1'b1, 4'd9, 18'h1234}));
    else n_pass++;
    tick();
    INIT_START = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge CPU_CLOCK);
      n_checks++;
      if (out_vec !== exp_out({1'b1, 4'(k), 18'd0}))
        $display("FAIL gti_zero[%0d] got=%h want=%h", k, out_vec, exp_out({1'b1, 4'(k), 18'd0}));
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_clear_mid_init();
    do_reset();
    INIT_START = 1'b1;
    tick();
    INIT_START = 1'b0;
    repeat (6) tick();  // registers 0..5 written, register 6 in the output stage
    #2 CLEAR = 1'b1;
    #1;
    n_checks++;
    if ({out_vec, INIT_BUSY} !== 40'd0)
      $display("FAIL clear_mid_init got=%h busy=%b want=0 busy=0", out_vec, INIT_BUSY);
    else n_pass++;
    #2 CLEAR = 1'b0;
    ALU_VALID = 1'b1;
    #1;
    n_checks++;
    if (ALU_READY !== 1'b1) $display("FAIL clear_state_run got=%b want=1", ALU_READY);
    else n_pass++;
    ALU_VALID = 1'b0;
    INIT_START = 1'b1;
    tick();
    INIT_START = 1'b0;
    @(negedge CPU_CLOCK);
    n_checks++;
    if ({out_vec, INIT_BUSY} !== {exp_out({1'b1, 4'd0, 18'd0}), 1'b1})
      $display("FAIL clear_restart got=%h busy=%b want=%h busy=1", out_vec, INIT_BUSY,
               exp_out({1'b1, 4'd0, 18'd0}));
    else n_pass++;
    repeat (17) tick();
  endtask

  // Randomized traffic against a queue-based model: every grant or init
  // request schedules the writes that must appear, one per cycle, in order.
  task automatic test_random();
    wr_t  q[$];
    wr_t  cur;
    int   init_rem;
    logic prio_mem, busy, e_alu, e_mem, alu_hold, mem_hold;
    do_reset();
    cur = '0; init_rem = 0; prio_mem = 1'b0; alu_hold = 1'b0; mem_hold = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!alu_hold) begin
        ALU_VALID = ($urandom_range(3) != 0); ALU_REG = 4'($urandom); ALU_DATA = 18'($urandom);
      end
      if (!mem_hold) begin
        MEM_VALID = ($urandom_range(3) != 0); MEM_REG = 4'($urandom); MEM_DATA = 18'($urandom);
      end
      INIT_START = ($urandom_range(39) == 0);
      busy = (init_rem > 0);
      e_alu = 1'b0; e_mem = 1'b0;
      if (!busy && !INIT_START) begin
        if (ALU_VALID && MEM_VALID) begin
          e_alu = !prio_mem; e_mem = prio_mem;
        end else begin
          e_alu = ALU_VALID; e_mem = MEM_VALID;
        end
      end
      @(negedge CPU_CLOCK);
      n_checks++;
      if ({ALU_READY, MEM_READY} !== {e_alu, e_mem})
        $display("FAIL rnd_ready[%0d] got=%b want=%b", c, {ALU_READY, MEM_READY}, {e_alu, e_mem});
      else n_pass++;
      n_checks++;
      if (INIT_BUSY !== busy) $display("FAIL rnd_busy[%0d] got=%b want=%b", c, INIT_BUSY, busy);
      else n_pass++;
      n_checks++;
      if (out_vec !== exp_out(cur)) $display("FAIL rnd_out[%0d] got=%h want=%h", c, out_vec, exp_out(cur));
      else n_pass++;
      if (init_rem > 0) begin
        init_rem--;
      end else if (INIT_START) begin
        init_rem = 16;
        for (int k = 0; k < 16; k++) q.push_back({1'b1, 4'(k), 18'd0});
      end else if (e_alu) begin
        q.push_back({1'b1, ALU_REG, ALU_DATA}); prio_mem = 1'b1;
      end else if (e_mem) begin
        q.push_back({1'b1, MEM_REG, MEM_DATA}); prio_mem = 1'b0;
      end
      cur = (q.size() > 0) ? q.pop_front() : '0;
      alu_hold = ALU_VALID && !e_alu;
      mem_hold = MEM_VALID && !e_mem;
      tick();
    end
    ALU_VALID = 1'b0; MEM_VALID = 1'b0; INIT_START = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_alternate();
    test_mem_then_contest();
    test_init();
    test_grant_then_init();
    test_clear_mid_init();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
